// File: rtl/lfsr_32bits_checker.sv
// lfsr_32bits_checker
// Receiving-end checker for a 32-bit Fibonacci LFSR stream
// (x^32 + x^30 + x^11 + x^5 + 1, one shift per word). It locks onto the
// incoming sequence without knowing the seed. Once locked, it flags every
// word that differs from the predicted next state.
//
// Parameters:
//   LOCK_N  consecutive correct predictions needed to declare lock (1..255)
//   LOSS_N  consecutive mismatches while locked that drop lock (1..255)
//   CNT_W   width of the error and word counters
//
// Ports:
//   clk        single clock, all logic on posedge
//   rst        synchronous, active-high reset
//   in_valid   a new generator word is present this cycle
//   in_val     generator word
//   clear      synchronous clear of the statistics counters only
//   locked     high while in LOCKED
//   err_pulse  one-cycle pulse per mismatching word while locked
//   err_cnt    saturating count of mismatches while locked
//   word_cnt   saturating count of words checked while locked
//
// Build option:
//   LFSR_CHK_STATS_EN  when defined, err_cnt/word_cnt and the clear logic
//                      are built. When undefined, both counters read 0 and
//                      clear is ignored.
module lfsr_32bits_checker #(
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned LOSS_N = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_val,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt
);

  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {
    S_SEEK   = 2'd0,
    S_SYNC   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [8:0] LOCK_C = 9'(LOCK_N);
  localparam logic [8:0] LOSS_C = 9'(LOSS_N);

  // One LFSR step: shift right, feedback from taps 0, 2, 21 and 27 into bit 31.
  function automatic word_t lfsr_next(input word_t v);
    return {v[0] ^ v[2] ^ v[21] ^ v[27], v[31:1]};
  endfunction

  state_t     state_q, state_d;
  word_t      ref_q, ref_d;
  logic [7:0] good_q, good_d;
  logic [7:0] bad_q, bad_d;
  word_t      pred;
  logic       match;
  logic [8:0] good_inc, bad_inc;
  logic       beat_locked, mism_locked;
  logic       err_pulse_d;
  logic       locked_q, err_pulse_q;

  assign pred     = lfsr_next(ref_q);
  assign match    = (in_val == pred);
  assign good_inc = {1'b0, good_q} + 9'd1;
  assign bad_inc  = {1'b0, bad_q} + 9'd1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_SEEK;
      ref_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    good_d  = good_q;
    bad_d   = bad_q;
    if (in_valid) begin
      case (state_q)
        S_SEEK: begin
          // All-zero is the LFSR lockup state and cannot seed.
          if (in_val != '0) begin
            ref_d   = in_val;
            good_d  = '0;
            state_d = S_SYNC;
          end
        end
        S_SYNC: begin
          if (in_val == '0) begin
            state_d = S_SEEK;
          end else if (match) begin
            ref_d  = in_val;
            good_d = good_inc[7:0];
            if (good_inc == LOCK_C) begin
              state_d = S_LOCKED;
              bad_d   = '0;
            end
          end else begin
            ref_d  = in_val;
            good_d = '0;
          end
        end
        S_LOCKED: begin
          if (match) begin
            ref_d = in_val;
            bad_d = '0;
          end else begin
            // Free-run on the prediction so a corrupted word never reseeds.
            ref_d = pred;
            bad_d = bad_inc[7:0];
            if (bad_inc == LOSS_C) begin
              state_d = S_SEEK;
            end
          end
        end
        default: state_d = S_SEEK;
      endcase
    end
  end

  // Output logic
  always_comb begin
    beat_locked = 1'b0;
    mism_locked = 1'b0;
    if (in_valid && (state_q == S_LOCKED)) begin
      beat_locked = 1'b1;
      mism_locked = !match;
    end
    err_pulse_d = mism_locked;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      locked_q    <= (state_d == S_LOCKED);
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;

`ifdef LFSR_CHK_STATS_EN
  logic [CNT_W-1:0] err_cnt_q, word_cnt_q;

  // clear has priority over a coincident count, so the result is 0, not 1.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      if (beat_locked && !(&word_cnt_q)) begin
        word_cnt_q <= word_cnt_q + CNT_W'(1);
      end
      if (mism_locked && !(&err_cnt_q)) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  assign err_cnt  = err_cnt_q;
  assign word_cnt = word_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = clear ^ beat_locked;
  assign err_cnt      = '0;
  assign word_cnt     = '0;
`endif

endmodule

// File: doc/lfsr_32bits_checker.md
# lfsr_32bits_checker

Receiving-end checker for the 32-bit Fibonacci LFSR stream (x^32 + x^30 + x^11 + x^5 + 1, one shift per update). It samples each word the generator presents, locks onto the sequence without needing the seed, and flags every word that deviates from the predicted next state. It sits on the bus self-test path, opposite the LFSR generator, and reports link or bus corruption to the debug and status registers.

## Interface

Parameters:
- LOCK_N, 4: consecutive correct predictions needed to declare lock (range 1..255).
- LOSS_N, 8: consecutive mismatches while locked that drop lock (range 1..255).
- CNT_W, 16: width of the error and word counters.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a new generator word is present this cycle.
- in_val  in  32 (word_t)  generator word.
- clear  in  1  synchronous clear of the statistics counters only.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse, one per mismatching word while locked.
- err_cnt  out  CNT_W  saturating count of mismatches while locked.
- word_cnt  out  CNT_W  saturating count of words checked while locked.

## Operation

- Prediction: next(v) = {v[0]^v[2]^v[21]^v[27], v[31:1]}. ref holds the last reference word.
- States: SEEK, SYNC, LOCKED. Only beats with in_valid=1 are acted on. Other cycles hold all state, except that err_pulse returns to 0.
- SEEK:
  - in_val==0: stay in SEEK. All-zero is the LFSR lockup state and cannot seed.
  - Otherwise: ref<=in_val, good<=0, go to SYNC.
- SYNC:
  - in_val==next(ref): ref<=in_val, good<=good+1. When good+1==LOCK_N, go to LOCKED and set bad<=0.
  - Mismatch, nonzero in_val: reseed with ref<=in_val, good<=0, stay in SYNC.
  - in_val==0: go to SEEK.
  - No error reporting in SEEK or SYNC.
- LOCKED:
  - Every beat: word_cnt++.
  - Match: ref<=in_val, bad<=0.
  - Mismatch: err_pulse<=1, err_cnt++, bad<=bad+1, and ref<=next(ref). The checker free-runs on its prediction and never reseeds from bad data. When bad+1==LOSS_N, go to SEEK.
  - An isolated corrupted word therefore costs exactly one error and keeps lock.
- Counters: saturate at all-ones with no wrap.
- clear:
  - Zeroes err_cnt and word_cnt and does not affect the state.
  - If clear coincides with a counted beat, clear wins: the counter becomes 0, not 1.
- rst:
  - Resets to SEEK with ref=0, good=0, bad=0.
  - Outputs reset to locked=0, err_pulse=0, err_cnt=0, word_cnt=0.
  - rst mid-lock aborts immediately, and the checker must reacquire.

## Timing

- All outputs are registered.
- err_pulse and the counter updates are visible the cycle after the offending beat.
- locked rises the cycle after the LOCK_N-th consecutive correct prediction. From a clean stream that is LOCK_N+1 valid beats after leaving reset.
- locked falls the cycle after the LOSS_N-th consecutive mismatch.
- Back-to-back valid beats every cycle are supported at full rate. Gaps of any length between beats are allowed.
- The prediction datapath is combinational from ref within one cycle; no pipelining.

## Configuration

- LFSR_CHK_STATS_EN defined: err_cnt and word_cnt and their clear logic are built as specified above.
- LFSR_CHK_STATS_EN undefined:
  - The counters are not instantiated, err_cnt and word_cnt are tied to 0, and clear is ignored.
  - locked and err_pulse behave identically in both builds.

## Test plan

- Lock from seed: drive 0xdeadface, then successive generator outputs starting 0xef56fd67, one per cycle.
  - Expect locked=1 one cycle after the 5th beat, with err_cnt=0.
  - Afterwards word_cnt increments by one per beat.
- Single corruption: once locked, replace one word with its bit 7 flipped.
  - Expect exactly one err_pulse, err_cnt=1, and locked held.
  - The next correct words produce no further errors.
- Loss of lock: once locked, feed 8 unrelated nonzero words.
  - Expect 8 err_pulses, err_cnt=8, and locked=0 the cycle after the 8th.
  - A clean stream then relocks after LOCK_N+1 beats.
- Zero and reseed: feed 0x00000000 in SEEK and expect the state to stay in SEEK.
  - In SYNC, a mismatching nonzero word reseeds with no err_pulse and no counter change.
- Saturation and clear: with CNT_W=4, force 20 locked mismatches with LOSS_N=255 and expect err_cnt=0xF.
  - Assert clear together with a mismatch beat and expect err_cnt=0.
- Gaps and reset: insert random in_valid=0 gaps in a clean stream and expect lock with no errors.
  - Assert rst while locked and expect locked=0 and both counters=0 on the next cycle.
